// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serial scan of bytes for the bit pattern 11011.
// A byte is taken on an in_valid/in_ready handshake and then shifted out MSB
// first, one bit per cycle, into a Mealy pattern detector. The detector state
// carries across byte boundaries. One byte is processed every 9 cycles.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   in_data     byte to scan (bit 7 first)
//   in_valid    in_data valid
//   in_ready    block accepts a byte this cycle (IDLE)
//   clr_cnt     synchronous clear of match_cnt (wins over a same-edge match)
//   flush       synchronous return of the detector to S0 (wins over a bit)
//   busy        byte being shifted
//   match_pulse one-cycle registered pulse per detected 11011
//   match_cnt   saturating detection count
//
// Build option: SEQ_DET_OVERLAP_EN selects overlapping detection (after a
// match the detector keeps the trailing "11"); default is non-overlapping.
module seq_det_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clr_cnt,
  input  logic       flush,
  output logic       busy,
  output logic       match_pulse,
  output logic [7:0] match_cnt
);

  typedef enum logic {IDLE, SHIFT} ctl_t;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_t;

`ifdef SEQ_DET_OVERLAP_EN
  localparam det_t AFTER_MATCH = S2;
`else
  localparam det_t AFTER_MATCH = S0;
`endif

  ctl_t       st, st_nx;
  det_t       det, det_nx;
  logic [7:0] shreg, shreg_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] cnt_nx;
  logic       consume, bit_in, match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      det         <= S0;
      shreg       <= 8'd0;
      idx         <= 3'd0;
      match_cnt   <= 8'd0;
      match_pulse <= 1'b0;
    end else begin
      st          <= st_nx;
      det         <= det_nx;
      shreg       <= shreg_nx;
      idx         <= idx_nx;
      match_cnt   <= cnt_nx;
      match_pulse <= match;
    end
  end

  always_comb begin
    st_nx    = st;
    shreg_nx = shreg;
    idx_nx   = idx;
    det_nx   = det;
    consume  = 1'b0;
    match    = 1'b0;
    bit_in   = shreg[7];

    case (st)
      IDLE: begin
        if (in_valid) begin
          shreg_nx = in_data;
          idx_nx   = 3'd7;
          st_nx    = SHIFT;
        end
      end
      SHIFT: begin
        consume  = 1'b1;
        shreg_nx = {shreg[6:0], 1'b0};
        // idx 0 marks the last bit; hold at 0 rather than wrap.
        if (idx == 3'd0) st_nx = IDLE;
        else             idx_nx = idx - 3'd1;
      end
      default: st_nx = IDLE;
    endcase

    if (consume) begin
      case (det)
        S0: det_nx = bit_in ? S1 : S0;
        S1: det_nx = bit_in ? S2 : S0;
        S2: det_nx = bit_in ? S2 : S3;
        S3: det_nx = bit_in ? S4 : S0;
        S4: begin
          if (bit_in) begin
            match  = 1'b1;
            det_nx = AFTER_MATCH;
          end else begin
            det_nx = S0;
          end
        end
        default: det_nx = S0;
      endcase
    end

    // flush overrides whatever the detector would have done this edge,
    // including suppressing a match; the byte keeps shifting.
    if (flush) begin
      det_nx = S0;
      match  = 1'b0;
    end

    cnt_nx = match_cnt;
    if (clr_cnt)                           cnt_nx = 8'd0;
    else if (match && match_cnt != 8'hFF)  cnt_nx = match_cnt + 8'd1;
  end

  assign in_ready = (st == IDLE);
  assign busy     = (st == SHIFT);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus random traffic, checked
// against a bit-history reference model. Expected pulses go into a
// scoreboard queue that an independent monitor drains.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       clr_cnt = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  logic       match_pulse;
  logic [7:0] match_cnt;

  seq_det_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clr_cnt(clr_cnt), .flush(flush), .busy(busy),
    .match_pulse(match_pulse), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int eg     = 0;   // number of rising edges so far
  bit armed  = 0;   // set once the DUT has seen a reset

  typedef struct { int eg; int cnt; } exp_t;
  exp_t sbq[$];

  // Reference model: bits still to shift, recent detector history, count.
  bit pend[$];
  bit hist[$];
  int m_cnt   = 0;
  bit m_pulse = 0;

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, eg, act, exp);
    end
  endtask

  function automatic bit would_match(input bit b, input bit fl);
    int n;
    n = hist.size();
    if (fl || pend.size() == 0 || n < 4) return 1'b0;
    return hist[n-4] && hist[n-3] && !hist[n-2] && hist[n-1] && b;
  endfunction

  task automatic model_step(input bit v, input logic [7:0] d, input bit clr,
                            input bit fl, input bit rst);
    bit m, b;
    m = 1'b0;
    if (rst) begin
      pend.delete(); hist.delete(); m_cnt = 0; m_pulse = 0;
      return;
    end
    if (pend.size() == 0) begin
      if (v) for (int i = 7; i >= 0; i--) pend.push_back(d[i]);
      if (fl) hist.delete();
    end else begin
      b = pend[0];
      m = would_match(b, fl);
      void'(pend.pop_front());
      if (fl) hist.delete();
      else begin
        hist.push_back(b);
        if (m && !OVERLAP) hist.delete();
        while (hist.size() > 4) void'(hist.pop_front());
      end
    end
    m_pulse = m;
    if (clr)                    m_cnt = 0;
    else if (m && m_cnt < 255)  m_cnt++;
    if (m) sbq.push_back('{eg: eg + 1, cnt: m_cnt});
  endtask

  // One clock cycle: drive at negedge, check, advance model, wait edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit clr,
                     input bit fl, input bit rst);
    @(negedge clk);
    in_valid = v; in_data = d; clr_cnt = clr; flush = fl; rst_n = !rst;
    if (armed) begin
      chk("in_ready", in_ready, pend.size() == 0);
      chk("busy", busy, pend.size() != 0);
      chk("match_cnt", match_cnt, m_cnt);
      chk("match_pulse", match_pulse, m_pulse);
    end
    model_step(v, d, clr, fl, rst);
    @(posedge clk);
    eg++;
    if (rst) armed = 1;
  endtask

  task automatic do_reset();
    cyc(0, 8'd0, 0, 0, 1);
    cyc(0, 8'd0, 0, 0, 0);
  endtask

  // Send one byte; fl_at/rst_at give the bit edge (1..8) for flush/reset.
  task automatic send_byte(input logic [7:0] d, input int fl_at, input int rst_at,
                           input bit clr_on_match);
    bit clr_pend, fl, c;
    clr_pend = clr_on_match;
    cyc(1, d, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      fl = (k == fl_at);
      c  = clr_pend && would_match(pend.size() ? pend[0] : 1'b0, fl);
      if (c) clr_pend = 0;
      // in_valid/in_data during SHIFT must be ignored
      cyc(1'($urandom_range(0, 1)), 8'($urandom), c, fl, k == rst_at);
      if (k == rst_at) break;
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (armed && match_pulse === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++; fails++;
        $display("FAIL sb_unexpected_pulse at edge %0d: got pulse expected none", eg);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_pulse_edge", eg, e.eg);
        chk("sb_pulse_cnt", match_cnt, e.cnt);
      end
    end
  end

  initial begin
    do_reset();

    // 0xDB: one match (two with overlap)
    send_byte(8'hDB, 0, 0, 0);
    #1 chk("db_cnt", match_cnt, OVERLAP ? 2 : 1);

    // detector state spans bytes
    do_reset();
    send_byte(8'h06, 0, 0, 0);
    send_byte(8'hC0, 0, 0, 0);
    #1 chk("span_cnt", match_cnt, 1);

    // reset mid-byte, then a clean byte
    do_reset();
    send_byte(8'hDB, 0, 4, 0);
    send_byte(8'h00, 0, 0, 0);
    #1 chk("rst_mid_cnt", match_cnt, 0);

    // flush on the match edge
    do_reset();
    send_byte(8'hDB, 5, 0, 0);
    #1 chk("flush_cnt", match_cnt, 0);

    // saturation, then clear on a match edge
    do_reset();
    repeat (300) send_byte(8'hDB, 0, 0, 0);
    #1 chk("sat_cnt", match_cnt, 255);
    send_byte(8'hDB, 0, 0, 1);
    #1 chk("clr_cnt", match_cnt, OVERLAP ? 1 : 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
          $urandom_range(0, 99) == 0);
    cyc(0, 8'd0, 0, 0, 0);
    cyc(0, 8'd0, 0, 0, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: in_data  input  8  byte to scan; bit 7 is serialized first.
REQ-004 SHALL: in_valid  input  1  in_data is valid this cycle.
REQ-005 SHALL: in_ready  output  1  block accepts a byte this cycle; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL: clr_cnt  input  1  synchronous clear of match_cnt.
REQ-007 SHALL: flush  input  1  synchronous return of the pattern detector to S0; match_cnt is unchanged.
REQ-008 SHALL: busy  output  1  high while a byte is being shifted.
REQ-009 SHALL: match_pulse  output  1  one-cycle registered pulse per detected 11011.
REQ-010 SHALL: match_cnt  output  8  saturating count of detections.

Function
REQ-011 SHALL: the control FSM has two states. IDLE has in_ready=1 and busy=0. SHIFT has in_ready=0 and busy=1.
REQ-012 SHALL: on the handshake edge (edge 0), the FSM loads in_data into an 8-bit shift register, sets the bit index to 7, and moves from IDLE to SHIFT.
REQ-013 SHALL: in SHIFT, shreg[7] is consumed by the detector at each edge, shreg shifts left, and the index decrements; 8 bits are consumed at edges 1..8.
REQ-014 SHALL: at edge 8 the FSM returns to IDLE; throughput is 1 byte per 9 cycles; in_ready is never high during SHIFT.
REQ-015 SHALL: the detector has Mealy states S0 (none), S1 ("1"), S2 ("11"), S3 ("110") and S4 ("1101"), and its state persists across byte boundaries.
REQ-016 SHALL: detector transitions are:
- S0: 1->S1, 0->S0
- S1: 1->S2, 0->S0
- S2: 1->S2, 0->S3
- S3: 1->S4, 0->S0
- S4: 0->S0, 1->match, next state per REQ-025
REQ-017 SHALL: the detector advances only on edges that consume a bit; it holds its state in IDLE.
REQ-018 SHALL: a match consumed at edge k drives match_pulse high for exactly the cycle between edges k and k+1.
REQ-019 SHALL: a match consumed at edge k updates match_cnt at edge k.
REQ-020 SHALL: match_cnt increments by 1 per match and saturates at 255 with no wrap-around.
REQ-021 SHALL: when clr_cnt and a match occur at the same edge, clr_cnt wins, match_cnt becomes 0, and match_pulse still fires.
REQ-022 SHALL: when flush and a bit are consumed at the same edge, flush wins: the detector goes to S0, no match is reported, and the FSM and shift register continue normally.
REQ-023 SHALL: in_valid held while in SHIFT is ignored; in_data is sampled only on the handshake edge.

Reset
REQ-024 SHALL: when rst_n is low at a rising edge, the block enters the following reset state, including mid-byte, where the partially shifted byte is discarded:
- FSM in IDLE, detector in S0
- shreg=0, index=0
- match_cnt=0, match_pulse=0
- busy=0, in_ready=1 from the next cycle

Configuration
REQ-025 SHALL: the macro SEQ_DET_OVERLAP_EN selects match behaviour:
- defined: after a match the detector goes to S2 (overlapping detection).
- undefined (default): after a match the detector goes to S0 (non-overlapping).
- No port or other behaviour differs.

Verification
REQ-026 SHALL: with reset, then in_data=0xDB, macro undefined -> exactly one match_pulse, in the cycle after edge 5; match_cnt=1; the detector ends in S2.
REQ-027 SHALL: the same stimulus as REQ-026 with SEQ_DET_OVERLAP_EN defined -> pulses after edges 5 and 8; match_cnt=2.
REQ-028 SHALL: with 0x06 then 0xC0 back-to-back (bits ...0110 | 11...) -> one match, at edge 2 of the second byte, proving detector state spans bytes.
REQ-029 SHALL: with 300 matches, then clr_cnt asserted on a match edge -> match_cnt sticks at 255, then reads 0; match_pulse still asserts on the clear edge.
REQ-030 SHALL: with rst_n low at edge 4 of 0xDB, then 0x00 -> no match, match_cnt=0, in_ready=1 after reset, and the next byte is accepted normally.
REQ-031 SHALL: with flush at edge 5 of 0xDB -> no match at edge 5; with the macro undefined, match_cnt remains 0.
